// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types and mode presets for the raster timing generator.
//   vga_mode_t describes one axis (visible, front porch, sync, back porch);
//   vga_preset_t bundles the horizontal and vertical axes of a video mode.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned vis;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_mode_t;

  typedef struct packed {
    vga_mode_t h;
    vga_mode_t v;
  } vga_preset_t;

  localparam vga_preset_t MODE_640x480 = '{
    h: '{vis: 640, fp: 16, sync: 96, bp: 48},
    v: '{vis: 480, fp: 10, sync: 2, bp: 33}
  };

  localparam vga_preset_t MODE_1280x720 = '{
    h: '{vis: 1280, fp: 110, sync: 40, bp: 220},
    v: '{vis: 720, fp: 5, sync: 5, bp: 20}
  };

  localparam vga_preset_t MODE_1920x1080 = '{
    h: '{vis: 1920, fp: 88, sync: 44, bp: 148},
    v: '{vis: 1080, fp: 4, sync: 5, bp: 36}
  };

  function automatic int unsigned mode_total(input vga_mode_t m);
    return m.vis + m.fp + m.sync + m.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_sync_axis
//   One raster axis: up-counter that wraps at total-1, plus combinational
//   decode of the sync window [vis+fp, vis+fp+sync) and the visible region.
//   The sync decode is active-high; the parent applies the polarity.
// Ports
//   clk_pix     in   pixel clock
//   rstn        in   async active-low reset, counter -> 0
//   i_load      in   load i_load_val (has priority over i_step)
//   i_load_val  in   value loaded when i_load=1
//   i_step      in   advance the count by one, wrapping at total-1
//   o_cnt       out  current count
//   o_last      out  count == total-1
//   o_sync      out  count inside the sync window
//   o_vis       out  count inside the visible region
module vga_sync_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W = 12,
  parameter vga_mode_t   MODE  = MODE_1920x1080.h
) (
  input  logic             clk_pix,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_sync,
  output logic             o_vis
);

  localparam int unsigned      L_TOT    = mode_total(MODE);
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(L_TOT - 1);
  localparam logic [CNT_W-1:0] L_VIS    = CNT_W'(MODE.vis);
  localparam logic [CNT_W-1:0] L_SYNC_S = CNT_W'(MODE.vis + MODE.fp);
  localparam logic [CNT_W-1:0] L_SYNC_E = CNT_W'(MODE.vis + MODE.fp + MODE.sync);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_step) begin
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == L_LAST);
  assign o_sync = (r_cnt >= L_SYNC_S) && (r_cnt < L_SYNC_E);
  assign o_vis  = (r_cnt < L_VIS);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator with frame-aligned run control.
//   Every output is registered: the decode of counter position (h,v) is
//   visible one clock after the counters hold it.
//   Optional feature macro: VGA_TIMING_PREFETCH_EN adds a second counter pair
//   running PREFETCH clocks ahead and the fetch_* ports.
// Ports
//   clk_pix      in   pixel clock
//   rstn         in   async active-low reset
//   en           in   run request (level)
//   running      out  high while in RUN or STOP
//   hsync/vsync  out  sync outputs, H_POL/V_POL active level
//   video_on     out  visible-area flag
//   pixel_x/y    out  coordinate when visible, else 0
//   line_start   out  pulse at h=0
//   frame_start  out  pulse at (0,0)
//   fetch_x/y    out  coordinate shown PREFETCH clocks later (macro only)
//   fetch_valid  out  that coordinate is visible (macro only)
//
// state | meaning
// IDLE  | counters held at 0, outputs at reset values
// RUN   | counters free-running, en=0 moves to STOP
// STOP  | finishing the frame; en=1 resumes, end of frame goes IDLE
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned H_VIS  = MODE_1920x1080.h.vis,
  parameter int unsigned H_FP   = MODE_1920x1080.h.fp,
  parameter int unsigned H_SYNC = MODE_1920x1080.h.sync,
  parameter int unsigned H_BP   = MODE_1920x1080.h.bp,
  parameter int unsigned V_VIS  = MODE_1920x1080.v.vis,
  parameter int unsigned V_FP   = MODE_1920x1080.v.fp,
  parameter int unsigned V_SYNC = MODE_1920x1080.v.sync,
  parameter int unsigned V_BP   = MODE_1920x1080.v.bp,
  parameter logic        H_POL  = 1'b0,
  parameter logic        V_POL  = 1'b0
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  parameter int unsigned PREFETCH = 2
`endif
) (
  input  logic             clk_pix,
  input  logic             rstn,
  input  logic             en,
  output logic             running,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CNT_W-1:0] fetch_x,
  output logic [CNT_W-1:0] fetch_y,
  output logic             fetch_valid
`endif
);

  localparam vga_mode_t L_H_MODE = '{vis: H_VIS, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_mode_t L_V_MODE = '{vis: V_VIS, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_active;
  logic             w_idle;

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_h_last, w_v_last;
  logic             w_h_sync, w_v_sync;
  logic             w_h_vis, w_v_vis;

  assign w_active = (r_state != S_IDLE);
  assign w_idle   = ~w_active;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en) w_state_nxt = S_RUN;
      S_RUN:  if (!en) w_state_nxt = S_STOP;
      S_STOP: begin
        if (en) w_state_nxt = S_RUN;
        else if (w_h_last && w_v_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Counters are held at 0 while idle, so the first RUN cycle sits at (0,0).
  vga_sync_axis #(.CNT_W(CNT_W), .MODE(L_H_MODE)) u_h_axis (
    .clk_pix    (clk_pix),
    .rstn       (rstn),
    .i_load     (w_idle),
    .i_load_val ('0),
    .i_step     (w_active),
    .o_cnt      (w_h_cnt),
    .o_last     (w_h_last),
    .o_sync     (w_h_sync),
    .o_vis      (w_h_vis)
  );

  vga_sync_axis #(.CNT_W(CNT_W), .MODE(L_V_MODE)) u_v_axis (
    .clk_pix    (clk_pix),
    .rstn       (rstn),
    .i_load     (w_idle),
    .i_load_val ('0),
    .i_step     (w_active && w_h_last),
    .o_cnt      (w_v_cnt),
    .o_last     (w_v_last),
    .o_sync     (w_v_sync),
    .o_vis      (w_v_vis)
  );

  logic             r_running, r_hsync, r_vsync, r_video_on;
  logic             r_line_start, r_frame_start;
  logic [CNT_W-1:0] r_pixel_x, r_pixel_y;
  logic             w_vis;
  logic             w_h_zero;

  assign w_vis    = w_active && w_h_vis && w_v_vis;
  assign w_h_zero = (w_h_cnt == '0);

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      r_running     <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_video_on    <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_running     <= w_active;
      r_hsync       <= (w_active && w_h_sync) ? H_POL : ~H_POL;
      r_vsync       <= (w_active && w_v_sync) ? V_POL : ~V_POL;
      r_video_on    <= w_vis;
      r_pixel_x     <= w_vis ? w_h_cnt : '0;
      r_pixel_y     <= w_vis ? w_v_cnt : '0;
      r_line_start  <= w_active && w_h_zero;
      r_frame_start <= w_active && w_h_zero && (w_v_cnt == '0);
    end
  end

  assign running     = r_running;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0] w_fh_cnt, w_fv_cnt;
  logic             w_fh_last, w_fh_vis, w_fv_vis;
  logic             w_fh_sync_unused, w_fv_sync_unused, w_fv_last_unused;
  logic             w_fvis;
  logic             r_fetch_valid;
  logic [CNT_W-1:0] r_fetch_x, r_fetch_y;

  // Lead pair preloads (PREFETCH,0) while idle so it starts exactly PREFETCH
  // pixels ahead and then wraps in lock-step with the main pair.
  vga_sync_axis #(.CNT_W(CNT_W), .MODE(L_H_MODE)) u_fh_axis (
    .clk_pix    (clk_pix),
    .rstn       (rstn),
    .i_load     (w_idle),
    .i_load_val (CNT_W'(PREFETCH)),
    .i_step     (w_active),
    .o_cnt      (w_fh_cnt),
    .o_last     (w_fh_last),
    .o_sync     (w_fh_sync_unused),
    .o_vis      (w_fh_vis)
  );

  vga_sync_axis #(.CNT_W(CNT_W), .MODE(L_V_MODE)) u_fv_axis (
    .clk_pix    (clk_pix),
    .rstn       (rstn),
    .i_load     (w_idle),
    .i_load_val ('0),
    .i_step     (w_active && w_fh_last),
    .o_cnt      (w_fv_cnt),
    .o_last     (w_fv_last_unused),
    .o_sync     (w_fv_sync_unused),
    .o_vis      (w_fv_vis)
  );

  assign w_fvis = w_active && w_fh_vis && w_fv_vis;

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      r_fetch_valid <= 1'b0;
      r_fetch_x     <= '0;
      r_fetch_y     <= '0;
    end else begin
      r_fetch_valid <= w_fvis;
      r_fetch_x     <= w_fvis ? w_fh_cnt : '0;
      r_fetch_y     <= w_fvis ? w_fv_cnt : '0;
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_x     = r_fetch_x;
  assign fetch_y     = r_fetch_y;
`endif

endmodule
